fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Asynchronous serial transmitter that drains the read port of our `fifo` buffer. It pops one word whenever it is idle and the FIFO is non-empty, then shifts that word out on a single line as an LSB-first frame: start bit, data bits, optional parity, stop bit. It sits between a `fifo` instance and the board-level TX pin, and is the consumer counterpart of the FIFO's write-side producers.

## Interface

- `B`, default 8: data bits per frame; must match the FIFO word width.
- `DIV`, default 16: clock cycles per serial bit; must be ≥2.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_data`  in  B  FIFO head word; valid whenever `fifo_empty`=0 (first-word fall-through).
- `fifo_rd`  out  1  pop strobe to the FIFO `rd` input.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is in progress.
- `tx_done_tick`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation

- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `fifo_rd` = (`reset`=1) & IDLE & ~`fifo_empty`. Combinational from registered state, so the pop and the capture happen in the same cycle.
  - In that cycle, latch `fifo_r_data` into the B-bit shift register and go to START.
- START: `tx`=0 for DIV cycles, then go to DATA.
- DATA: `tx` = shift[0] for DIV cycles per bit. Shift right after each bit. After B bits, go to PARITY if compiled in, else STOP.
- PARITY: `tx` = even parity (XOR of the captured word) for DIV cycles, then go to STOP.
- STOP: `tx`=1 for DIV cycles. `tx_done_tick`=1 on the final cycle, then go to IDLE.
- Counters:
  - The tick counter counts 0..DIV-1 and is sized `$clog2(DIV)`.
  - The bit counter counts 0..B-1 and is sized `$clog2(B)`, minimum 1 bit.
  - Both counters clear on every state transition.
- `busy` = (state != IDLE).
- `tx` comes from a flop, so it is glitch-free.
- `fifo_empty` and `fifo_r_data` are ignored outside IDLE. A write arriving mid-frame is picked up at the next IDLE.
- At most one `fifo_rd` pulse per frame. `fifo_rd` is never asserted while `fifo_empty`=1.

## Timing

- Reset values: state IDLE, `tx`=1, `busy`=0, `tx_done_tick`=0, `fifo_rd`=0, counters 0, shift register 0.
- Reset mid-frame takes effect immediately and asynchronously:
  - `tx` returns to 1.
  - The frame is truncated.
  - The popped word is lost and is not re-read.
- Let cycle T be the IDLE cycle with `fifo_rd`=1. Then:
  - `tx` falls at T+1.
  - Data bit k is driven from T+1+(1+k)·DIV for DIV cycles.
  - The stop bit ends at T+(B+2)·DIV, the cycle in which `tx_done_tick` is high.
- Back-to-back frames (FIFO never empty): one IDLE cycle separates frames.
  - Pop-to-pop period is (B+2)·DIV+1 cycles, or (B+3)·DIV+1 with parity.
- If `reset` deasserts while the FIFO is non-empty, the first pop occurs in the first clock edge's cycle after release.

## Configuration

- `FIFO_UART_TX_PARITY_EN` defined:
  - The PARITY state exists.
  - One even-parity bit is inserted between the last data bit and the stop bit.
  - Frame length is B+3 bits.
- Not defined:
  - No PARITY state.
  - Frame length is B+2 bits.
  - No parity logic is synthesized.

## Test plan

- **Single word** (B=8, DIV=4), FIFO holds 0xA5 → one `fifo_rd` pulse. `tx` is low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4. `tx_done_tick` fires 40 cycles after the pop.
- **Burst**: three words 0x01, 0xFF, 0x3C queued → `fifo_rd` pulses exactly 41 cycles apart. Serial frames decode in order to 0x01, 0xFF, 0x3C. `busy` is low for exactly 1 cycle between frames.
- **Empty FIFO** held 200 cycles → `fifo_rd`=0, `tx`=1, `busy`=0 throughout. A word written mid-frame is not popped until the following IDLE cycle.
- **Reset mid-frame**: assert `reset`=0 during data bit 3 of 0x00 → `tx`=1 and `busy`=0 immediately (before the next edge). After release, the next queued word transmits from a fresh start bit.
- **Parity** (`FIFO_UART_TX_PARITY_EN` defined), words 0x07 and 0x03 → parity bit 1 for 0x07 and 0 for 0x03. Pop spacing is 45 cycles at DIV=4.
- **Minimum divider** DIV=2, B=5, word 0x15 → every bit lasts exactly 2 cycles. Frame bits are 0,1,0,1,0,1,1. The tick counter wraps correctly.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a first-word-fall-through fifo into LSB-first UART frames; tx falls 1 cycle after the pop.
// Pops only from IDLE, one word per frame (the line itself has no backpressure); define FIFO_UART_TX_PARITY_EN for an even-parity bit.
module fifo_uart_tx #(
  parameter int B   = 8,
  parameter int DIV = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_r_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         busy,
  output logic         tx_done_tick
);

  localparam int TW = $clog2(DIV);
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(B - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [BW-1:0] bitn, bitn_n;
  logic [B-1:0]  shift, shift_n;
  logic          tx_n;
  logic          last_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic          par, par_n;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tick  <= '0;
      bitn  <= '0;
      shift <= '0;
      tx    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bitn  <= bitn_n;
      shift <= shift_n;
      tx    <= tx_n;
`ifdef FIFO_UART_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  assign last_tick = (tick == TICK_MAX);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n      = state;
    tick_n       = tick;
    bitn_n       = bitn;
    shift_n      = shift;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_n        = par;
`endif
    case (state)
      IDLE: begin
        if (reset && !fifo_empty) begin
          fifo_rd = 1'b1;
          shift_n = fifo_r_data;
`ifdef FIFO_UART_TX_PARITY_EN
          par_n   = ^fifo_r_data;
`endif
          state_n = START;
          tick_n  = '0;
          bitn_n  = '0;
        end
      end
      START: begin
        if (last_tick) begin
          state_n = DATA;
          tick_n  = '0;
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      DATA: begin
        if (last_tick) begin
          tick_n  = '0;
          shift_n = shift >> 1;
          if (bitn == BIT_MAX) begin
            bitn_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bitn_n = bitn + BW'(1);
          end
        end else begin
          tick_n = tick + TW'(1);
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (last_tick) begin
          state_n = STOP;
          tick_n  = '0;
        end else begin
          tick_n = tick + TW'(1);
        end
      end
`endif
      STOP: begin
        if (last_tick) begin
          tx_done_tick = 1'b1;
          state_n      = IDLE;
          tick_n       = '0;
        end else begin
          tick_n = tick + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tick_n  = '0;
        bitn_n  = '0;
      end
    endcase
  end

  // Line level follows the next state so the registered tx lines up with the state it belongs to.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:  tx_n = 1'b0;
      DATA:   tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-backed fifo feeds the DUT; a frame-timing model predicts every output per cycle.
module tb_fifo_uart_tx;

  localparam int B   = 8;
  localparam int DIV = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB  = B + 3;
  localparam int FB2 = 8;
`else
  localparam int NB  = B + 2;
  localparam int FB2 = 7;
`endif
  localparam int FLEN = NB * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         fifo_empty;
  logic [B-1:0] fifo_r_data;
  logic         fifo_rd, tx, busy, tx_done_tick;

  logic         e2;
  logic [4:0]   d2;
  logic         rd2, tx2, busy2, done2;

  fifo_uart_tx #(.B(B), .DIV(DIV)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
    .fifo_rd(fifo_rd), .tx(tx), .busy(busy), .tx_done_tick(tx_done_tick)
  );

  fifo_uart_tx #(.B(5), .DIV(2)) dut2 (
    .clk(clk), .reset(reset), .fifo_empty(e2), .fifo_r_data(d2),
    .fifo_rd(rd2), .tx(tx2), .busy(busy2), .tx_done_tick(done2)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int push_pct = 0;
  logic [B-1:0] q[$];
  int pop_log[$];
  int t0 = 0;
  int busy_until = 0;
  logic [B-1:0] w0 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
  endtask

  // Frame bit idx of word w: start, LSB-first data, optional even parity, stop.
  function automatic logic fbit(input logic [B-1:0] w, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= B) return w[idx-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (idx == B + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  task automatic drive();
    fifo_empty  = (q.size() == 0);
    fifo_r_data = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic cycle_once();
    logic in_frame, e_tx, e_rd, rd_seen;
    @(negedge clk);
    cyc++;
    in_frame = reset && (cyc > t0) && (cyc <= busy_until);
    e_tx     = in_frame ? fbit(w0, (cyc - t0 - 1) / DIV) : 1'b1;
    e_rd     = reset && !in_frame && (q.size() != 0);
    chk("fifo_rd", 32'(fifo_rd), 32'(e_rd));
    chk("tx", 32'(tx), 32'(e_tx));
    chk("busy", 32'(busy), 32'(in_frame));
    chk("tx_done_tick", 32'(tx_done_tick), 32'(in_frame && (cyc == busy_until)));
    rd_seen = fifo_rd;
    if (!reset) begin
      t0 = 0;
      busy_until = 0;
    end else if (e_rd) begin
      t0 = cyc;
      w0 = q[0];
      busy_until = cyc + FLEN;
    end
    @(posedge clk);
    if (rd_seen) begin
      if (q.size() != 0) void'(q.pop_front());
      pop_log.push_back(cyc);
    end
    #1;
    if (reset && ($urandom_range(99) < push_pct)) q.push_back(B'($urandom));
    drive();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f2;
    int cyc_rel;
    int guard;
    f2    = 8'hEA;
    reset = 1'b0;
    e2    = 1'b1;
    d2    = '0;
    drive();
    repeat (3) cycle_once();
    reset = 1'b1;

    // Minimum divider: B=5, DIV=2, word 0x15.
    e2 = 1'b0;
    d2 = 5'h15;
    @(negedge clk);
    chk("rd2", 32'(rd2), 32'd1);
    chk("busy2_idle", 32'(busy2), 32'd0);
    @(posedge clk);
    #1 e2 = 1'b1;
    for (int j = 0; j < FB2 * 2; j++) begin
      @(negedge clk);
      chk("tx2", 32'(tx2), 32'(f2[j/2]));
      chk("done2", 32'(done2), 32'(j == FB2 * 2 - 1));
      chk("busy2", 32'(busy2), 32'd1);
      chk("rd2_once", 32'(rd2), 32'd0);
    end
    @(negedge clk);
    chk("busy2_end", 32'(busy2), 32'd0);
    chk("tx2_end", 32'(tx2), 32'd1);
    @(posedge clk);
    #1;

    // Burst of three back-to-back words.
    q.push_back(8'h01);
    q.push_back(8'hFF);
    q.push_back(8'h3C);
    drive();
    pop_log.delete();
    repeat (3 * (FLEN + 1) + 8) cycle_once();
    chk("burst_pops", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() == 3)
      for (int i = 0; i < 2; i++)
        chk("pop_gap", 32'(pop_log[i+1] - pop_log[i]), 32'(FLEN + 1));

    // Empty fifo held idle.
    repeat (200) cycle_once();

    // Random traffic, including writes that land mid-frame.
    push_pct = 2;
    repeat (1500) cycle_once();
    push_pct = 0;
    guard = 0;
    while (((q.size() != 0) || (cyc <= busy_until)) && (guard < 3000)) begin
      cycle_once();
      guard++;
    end
    chk("drained", 32'(q.size() == 0), 32'd1);

    // Reset during data bit 3 of 0x00.
    q.push_back(8'h00);
    drive();
    cycle_once();
    guard = 0;
    while ((cyc < t0 + 1 + 4 * DIV + 1) && (guard < 200)) begin
      cycle_once();
      guard++;
    end
    #2 reset = 1'b0;
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    q.push_back(8'hC3);
    drive();
    repeat (3) cycle_once();
    reset = 1'b1;
    cyc_rel = cyc;
    pop_log.delete();
    repeat (FLEN + 20) cycle_once();
    chk("post_rst_pops", 32'(pop_log.size()), 32'd1);
    if (pop_log.size() != 0) chk("post_rst_pop_cyc", 32'(pop_log[0]), 32'(cyc_rel + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
